// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Merges two writeback requesters (A = ALU, B = load/memory) into one in-order
// queue that retires one write per cycle onto the single register-file port.
// A lookup port reports the youngest pending write to a register for forwarding.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   A_VALID/A_READY/A_ADDR/A_DATA   ALU writeback request
//   B_VALID/B_READY/B_ADDR/B_DATA   load writeback request
//   WE/WA/WD                 register-file write port (head of queue)
//   LK_ADDR/LK_HIT/LK_DATA   pending-write lookup (combinational)
//   COUNT                    number of queued writes
module regfile_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         A_VALID,
    output logic                         A_READY,
    input  logic [ADDR_WIDTH-1:0]        A_ADDR,
    input  logic [DATA_WIDTH-1:0]        A_DATA,
    input  logic                         B_VALID,
    output logic                         B_READY,
    input  logic [ADDR_WIDTH-1:0]        B_ADDR,
    input  logic [DATA_WIDTH-1:0]        B_DATA,
    output logic                         WE,
    output logic [ADDR_WIDTH-1:0]        WA,
    output logic [DATA_WIDTH-1:0]        WD,
    input  logic [ADDR_WIDTH-1:0]        LK_ADDR,
    output logic                         LK_HIT,
    output logic [DATA_WIDTH-1:0]        LK_DATA,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    logic                  w_pop;
    logic                  w_need_a;
    logic                  w_push_a;
    logic                  w_push_b;
    logic [CNT_W-1:0]      w_free;
    logic [PTR_W-1:0]      w_b_slot;
    logic [PTR_W-1:0]      w_wr_next;
    logic [PTR_W-1:0]      w_rd_next;
    logic [CNT_W-1:0]      w_count_next;

    // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned       inc);
        int unsigned s;
        s = 32'(ptr) + inc;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Handshake and push/pop decisions.
    always_comb begin
        w_pop    = (r_count != '0);
        // The head retires at this edge, so its slot is reusable by a push.
        w_free   = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
        w_need_a = A_VALID && (A_ADDR != '0);
        A_READY  = !rst;
        B_READY  = !rst && (w_need_a ? (w_free >= CNT_W'(2)) : 1'b1);
        // Address-0 writes complete the handshake but never enter the queue.
        w_push_a = w_need_a && A_READY;
        w_push_b = B_VALID && B_READY && (B_ADDR != '0);
        w_b_slot = w_push_a ? ptr_add(r_wr_ptr, 1) : r_wr_ptr;
        w_wr_next = ptr_add(r_wr_ptr, 32'(w_push_a) + 32'(w_push_b));
        w_rd_next = ptr_add(r_rd_ptr, 32'(w_pop));
        w_count_next = r_count - CNT_W'(w_pop) + CNT_W'(w_push_a) + CNT_W'(w_push_b);
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= w_wr_next;
            r_count  <= w_count_next;
        end
    end

    // Entry storage; A lands before B so B is younger on a same-cycle pair.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_addr[r_wr_ptr] <= A_ADDR;
            r_data[r_wr_ptr] <= A_DATA;
        end
        if (w_push_b) begin
            r_addr[w_b_slot] <= B_ADDR;
            r_data[w_b_slot] <= B_DATA;
        end
    end

    // Register-file port driven straight from the queue head.
    always_comb begin
        WE    = w_pop;
        WA    = w_pop ? r_addr[r_rd_ptr] : '0;
        WD    = w_pop ? r_data[r_rd_ptr] : '0;
        COUNT = r_count;
    end

    // Forwarding lookup: walk oldest to youngest so the youngest match wins.
    always_comb begin
        LK_HIT  = 1'b0;
        LK_DATA = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((i < 32'(r_count)) && (LK_ADDR != '0) &&
                (r_addr[ptr_add(r_rd_ptr, i)] == LK_ADDR)) begin
                LK_HIT  = 1'b1;
                LK_DATA = r_data[ptr_add(r_rd_ptr, i)];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors, a queue-based reference
// model checked every cycle, and literal expectations pinning key points.
module tb_regfile_write_arbiter;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          A_VALID, B_VALID;
    logic          A_READY, B_READY;
    logic [AW-1:0] A_ADDR, B_ADDR, WA, LK_ADDR;
    logic [DW-1:0] A_DATA, B_DATA, WD, LK_DATA;
    logic          WE, LK_HIT;
    logic [2:0]    COUNT;

    regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
        .WE(WE), .WA(WA), .WD(WD),
        .LK_ADDR(LK_ADDR), .LK_HIT(LK_HIT), .LK_DATA(LK_DATA),
        .COUNT(COUNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t q[$];
    int   passed = 0;
    int   total  = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Model: a write from a requester is accepted when the queue, after this
    // cycle's retirement, still has room for everything that must be queued.
    function automatic bit m_b_ready();
        int sz, room, need;
        if (rst) return 1'b0;
        sz   = q.size();
        room = DEP - sz + ((sz > 0) ? 1 : 0);
        need = (A_VALID && A_ADDR != 0) ? 2 : 1;
        return room >= need;
    endfunction

    task automatic model_check();
        logic          e_we, e_hit;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd, e_lk;
        e_we = (q.size() != 0);
        e_wa = e_we ? q[0].a : '0;
        e_wd = e_we ? q[0].d : '0;
        e_hit = 1'b0;
        e_lk  = '0;
        if (LK_ADDR != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == LK_ADDR) begin
                    e_hit = 1'b1;
                    e_lk  = q[i].d;
                    break;
                end
            end
        end
        chk("a_ready", 32'(A_READY), 32'(!rst));
        chk("b_ready", 32'(B_READY), 32'(m_b_ready()));
        chk("we",      32'(WE),      32'(e_we));
        chk("wa",      32'(WA),      32'(e_wa));
        chk("wd",      WD,           e_wd);
        chk("lk_hit",  32'(LK_HIT),  32'(e_hit));
        chk("lk_data", LK_DATA,      e_lk);
        chk("count",   32'(COUNT),   32'(q.size()));
    endtask

    task automatic apply(input logic r, input logic av, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] ba,
                         input logic [DW-1:0] bd, input logic [AW-1:0] lk);
        @(negedge clk);
        rst = r; A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd; LK_ADDR = lk;
        #1;
        if (chk_en) model_check();
    endtask

    task automatic tick();
        bit acc_b;
        acc_b = m_b_ready();
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (A_VALID && A_ADDR != 0) q.push_back('{a: A_ADDR, d: A_DATA});
            if (B_VALID && acc_b && B_ADDR != 0) q.push_back('{a: B_ADDR, d: B_DATA});
        end
    endtask

    task automatic idle(input logic [AW-1:0] lk);
        apply(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, lk);
    endtask

    int bi;

    initial begin
        rst = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0;
        A_ADDR = '0; B_ADDR = '0; A_DATA = '0; B_DATA = '0; LK_ADDR = '0;
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk_en = 1'b1;
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_a_ready", 32'(A_READY), 32'd0);
        tick();

        // A only.
        apply(1'b0, 1, 5'd5, 32'h1234, 0, 0, 0, 0);
        chk("t1_count0", 32'(COUNT), 32'd0);
        tick();
        idle('0);
        chk("t1_we", 32'(WE), 32'd1);
        chk("t1_wa", 32'(WA), 32'd5);
        chk("t1_wd", WD, 32'h1234);
        tick();
        idle('0);
        chk("t1_we_off", 32'(WE), 32'd0);
        chk("t1_count", 32'(COUNT), 32'd0);
        tick();

        // Collision.
        apply(1'b0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0);
        chk("t2_a_ready", 32'(A_READY), 32'd1);
        chk("t2_b_ready", 32'(B_READY), 32'd1);
        tick();
        idle('0);
        chk("t2_wa1", 32'(WA), 32'd1);
        chk("t2_wd1", WD, 32'hA);
        tick();
        idle('0);
        chk("t2_wa2", 32'(WA), 32'd2);
        chk("t2_wd2", WD, 32'hB);
        tick();
        idle('0); tick();

        // Saturation: B holds its request until accepted.
        bi = 0;
        for (int i = 0; i < 8; i++) begin
            bit bacc;
            apply(1'b0, 1, 5'(8 + i), 32'hA000 + 32'(i),
                  1, 5'(16 + bi), 32'hB000 + 32'(bi), 5'(16 + bi));
            if (i == 3) begin
                chk("t3_count_full", 32'(COUNT), 32'd4);
                chk("t3_b_stall", 32'(B_READY), 32'd0);
                chk("t3_a_ready", 32'(A_READY), 32'd1);
            end
            bacc = m_b_ready();
            tick();
            if (bacc) bi++;
        end

        // x0 discard with a full queue: B still fits in the single free slot.
        apply(1'b0, 1, 5'd0, 32'hFFFF, 1, 5'd3, 32'h3, 5'd3);
        chk("t4_count", 32'(COUNT), 32'd4);
        chk("t4_b_ready", 32'(B_READY), 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            idle(5'd3);
            tick();
        end
        chk("t4_drained", 32'(COUNT), 32'd0);

        // Forwarding.
        apply(1'b0, 1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 5'd7);
        tick();
        idle(5'd7);
        chk("t5_hit", 32'(LK_HIT), 32'd1);
        chk("t5_data", LK_DATA, 32'd2);
        tick();
        idle(5'd0);
        chk("t5_lk0_hit", 32'(LK_HIT), 32'd0);
        chk("t5_lk0_data", LK_DATA, 32'd0);
        tick();
        idle(5'd7);
        chk("t5_drained_hit", 32'(LK_HIT), 32'd0);
        tick();

        // Reset mid-operation.
        apply(1'b0, 1, 5'd10, 32'h10, 1, 5'd11, 32'h11, 0); tick();
        apply(1'b0, 1, 5'd12, 32'h12, 1, 5'd13, 32'h13, 0); tick();
        apply(1'b1, 1, 5'd14, 32'h14, 1, 5'd15, 32'h15, 5'd12);
        chk("t6_count3", 32'(COUNT), 32'd3);
        chk("t6_a_rst", 32'(A_READY), 32'd0);
        chk("t6_b_rst", 32'(B_READY), 32'd0);
        tick();
        idle(5'd12);
        chk("t6_we", 32'(WE), 32'd0);
        chk("t6_count", 32'(COUNT), 32'd0);
        chk("t6_hit", 32'(LK_HIT), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(5'd13);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
